vga_timing_gen: RTL and testbench

- Generates the horizontal and vertical pixel counters (Count_h, Count_v) consumed by the colour-assignment stage, plus Hsync/Vsync for the VGA connector.
- Derives a pixel tick from the system clock by integer division.
- Timing fields come from the Config unit at run time. They are shadowed and take effect only at a frame boundary, so a mode change never tears a frame.

---
 rtl/vga_timing_gen.sv | 185 ++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-rate divider, horizontal/vertical counters, syncs and
// line/frame pulses. Run-time timing fields are shadowed and only adopted at a frame wrap.
module vga_timing_gen #(
    parameter int REZ_MAX_WIDTH = 11,
    parameter int CLK_DIV       = 4,
    parameter bit SYNC_POL      = 1'b0,
    parameter int DEF_H_ACTIVE  = 640,
    parameter int DEF_H_FRONT   = 16,
    parameter int DEF_H_SYNC    = 96,
    parameter int DEF_H_BACK    = 48,
    parameter int DEF_V_ACTIVE  = 480,
    parameter int DEF_V_FRONT   = 10,
    parameter int DEF_V_SYNC    = 2,
    parameter int DEF_V_BACK    = 33
) (
    input  logic                     Clk,
    input  logic                     Rst_n,
    input  logic                     En,
    input  logic [REZ_MAX_WIDTH-1:0] H_active,
    input  logic [REZ_MAX_WIDTH-1:0] H_front,
    input  logic [REZ_MAX_WIDTH-1:0] H_sync,
    input  logic [REZ_MAX_WIDTH-1:0] H_back,
    input  logic [REZ_MAX_WIDTH-1:0] V_active,
    input  logic [REZ_MAX_WIDTH-1:0] V_front,
    input  logic [REZ_MAX_WIDTH-1:0] V_sync,
    input  logic [REZ_MAX_WIDTH-1:0] V_back,
    output logic [REZ_MAX_WIDTH-1:0] Count_h,
    output logic [REZ_MAX_WIDTH-1:0] Count_v,
    output logic                     Hsync,
    output logic                     Vsync,
    output logic                     Pixel_tick,
    output logic                     Line_start,
    output logic                     Frame_start
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int TW    = REZ_MAX_WIDTH + 2;
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TW-1:0]    TOTAL_MAX = TW'((1 << REZ_MAX_WIDTH) - 1);

    typedef logic [REZ_MAX_WIDTH-1:0] field_t;
    typedef struct packed {
        field_t h_active;
        field_t h_front;
        field_t h_sync;
        field_t h_back;
        field_t v_active;
        field_t v_front;
        field_t v_sync;
        field_t v_back;
    } timing_t;

    localparam timing_t TIMING_DEF = '{
        h_active: field_t'(DEF_H_ACTIVE), h_front: field_t'(DEF_H_FRONT),
        h_sync:   field_t'(DEF_H_SYNC),   h_back:  field_t'(DEF_H_BACK),
        v_active: field_t'(DEF_V_ACTIVE), v_front: field_t'(DEF_V_FRONT),
        v_sync:   field_t'(DEF_V_SYNC),   v_back:  field_t'(DEF_V_BACK)
    };

    function automatic logic [TW-1:0] total4(input field_t a, input field_t b,
                                             input field_t c, input field_t d);
        return TW'(a) + TW'(b) + TW'(c) + TW'(d);
    endfunction

    // Sync window is [active+front, active+front+width-1]; width 0 gives an empty window.
    function automatic logic in_sync(input field_t cnt, input field_t act,
                                     input field_t fr, input field_t wid);
        logic [TW-1:0] lo_s;
        lo_s = TW'(act) + TW'(fr);
        return (TW'(cnt) >= lo_s) && (TW'(cnt) < lo_s + TW'(wid));
    endfunction

    logic [DIV_W-1:0] div_r, div_nxt_s;
    logic             adv_s;
    timing_t          shadow_r, shadow_nxt_s, cfg_s;
    logic             cfg_ok_s;
    logic [TW-1:0]    h_total_s, v_total_s;
    logic             h_last_s, v_last_s;
    field_t           count_h_r, count_v_r, count_h_nxt_s, count_v_nxt_s;
    logic             line_nxt_s, frame_nxt_s;
    logic             hsync_r, vsync_r, hsync_nxt_s, vsync_nxt_s;
    logic             pixel_tick_r, line_start_r, frame_start_r;

    assign cfg_s = '{
        h_active: H_active, h_front: H_front, h_sync: H_sync, h_back: H_back,
        v_active: V_active, v_front: V_front, v_sync: V_sync, v_back: V_back
    };
    assign cfg_ok_s = (H_active != '0) && (V_active != '0) &&
                      (total4(H_active, H_front, H_sync, H_back) <= TOTAL_MAX) &&
                      (total4(V_active, V_front, V_sync, V_back) <= TOTAL_MAX);

    assign h_total_s = total4(shadow_r.h_active, shadow_r.h_front, shadow_r.h_sync, shadow_r.h_back);
    assign v_total_s = total4(shadow_r.v_active, shadow_r.v_front, shadow_r.v_sync, shadow_r.v_back);
    assign h_last_s  = (TW'(count_h_r) == h_total_s - TW'(1));
    assign v_last_s  = (TW'(count_v_r) == v_total_s - TW'(1));

    // Divider phase; the counters advance on the edge where the divider reaches its last phase.
    always_comb begin
        div_nxt_s = '0;
        adv_s     = 1'b0;
        if (En) begin
            if (div_r == DIV_LAST) begin
                div_nxt_s = '0;
            end else begin
                div_nxt_s = div_r + DIV_W'(1);
            end
            adv_s = (div_nxt_s == DIV_LAST);
        end else begin
            div_nxt_s = '0;
            adv_s     = 1'b0;
        end
    end

    // Next raster position, pulses and shadow reload at the frame wrap.
    always_comb begin
        count_h_nxt_s = count_h_r;
        count_v_nxt_s = count_v_r;
        shadow_nxt_s  = shadow_r;
        line_nxt_s    = 1'b0;
        frame_nxt_s   = 1'b0;
        if (adv_s) begin
            if (h_last_s) begin
                count_h_nxt_s = '0;
                line_nxt_s    = 1'b1;
                if (v_last_s) begin
                    count_v_nxt_s = '0;
                    frame_nxt_s   = 1'b1;
                    if (cfg_ok_s) begin
                        shadow_nxt_s = cfg_s;
                    end else begin
                        shadow_nxt_s = shadow_r;
                    end
                end else begin
                    count_v_nxt_s = count_v_r + field_t'(1);
                end
            end else begin
                count_h_nxt_s = count_h_r + field_t'(1);
            end
        end else begin
            count_h_nxt_s = count_h_r;
        end
    end

    // Syncs follow the next counter values so they leave the registers together.
    always_comb begin
        hsync_nxt_s = in_sync(count_h_nxt_s, shadow_nxt_s.h_active, shadow_nxt_s.h_front,
                              shadow_nxt_s.h_sync) ~^ SYNC_POL;
        vsync_nxt_s = in_sync(count_v_nxt_s, shadow_nxt_s.v_active, shadow_nxt_s.v_front,
                              shadow_nxt_s.v_sync) ~^ SYNC_POL;
    end

    // State and output registers.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            div_r         <= '0;
            shadow_r      <= TIMING_DEF;
            count_h_r     <= '0;
            count_v_r     <= '0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            pixel_tick_r  <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            div_r         <= div_nxt_s;
            shadow_r      <= shadow_nxt_s;
            count_h_r     <= count_h_nxt_s;
            count_v_r     <= count_v_nxt_s;
            hsync_r       <= hsync_nxt_s;
            vsync_r       <= vsync_nxt_s;
            pixel_tick_r  <= adv_s;
            line_start_r  <= line_nxt_s;
            frame_start_r <= frame_nxt_s;
        end
    end

    assign Count_h     = count_h_r;
    assign Count_v     = count_v_r;
    assign Hsync       = hsync_r;
    assign Vsync       = vsync_r;
    assign Pixel_tick  = pixel_tick_r;
    assign Line_start  = line_start_r;
    assign Frame_start = frame_start_r;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench: directed 640x480 checks on a CLK_DIV=4 instance, then a randomized run of a
// small-mode CLK_DIV=2 high-active-sync instance against a pixel-index reference model.
module tb_vga_timing_gen;

    localparam int WB    = 5;
    localparam int DIV_B = 2;
    localparam int DEF_B [8] = '{8, 2, 3, 2, 5, 1, 2, 1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            if (n_errors <= 40) $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- instance A: 640x480 defaults, CLK_DIV=4, active-low syncs
    logic        rst_a_n = 1'b0, en_a = 1'b0;
    logic [10:0] cfg_a [8];
    logic [10:0] count_h_a, count_v_a;
    logic        hsync_a, vsync_a, tick_a, line_a, frame_a;

    vga_timing_gen #(.REZ_MAX_WIDTH(11), .CLK_DIV(4), .SYNC_POL(1'b0)) dut_a (
        .Clk(clk), .Rst_n(rst_a_n), .En(en_a),
        .H_active(cfg_a[0]), .H_front(cfg_a[1]), .H_sync(cfg_a[2]), .H_back(cfg_a[3]),
        .V_active(cfg_a[4]), .V_front(cfg_a[5]), .V_sync(cfg_a[6]), .V_back(cfg_a[7]),
        .Count_h(count_h_a), .Count_v(count_v_a), .Hsync(hsync_a), .Vsync(vsync_a),
        .Pixel_tick(tick_a), .Line_start(line_a), .Frame_start(frame_a));

    // ---------------- instance B: small defaults, CLK_DIV=2, active-high syncs
    logic          rst_b_n = 1'b0, en_b = 1'b0;
    logic [WB-1:0] cfg_b [8];
    logic [WB-1:0] count_h_b, count_v_b;
    logic          hsync_b, vsync_b, tick_b, line_b, frame_b;

    vga_timing_gen #(.REZ_MAX_WIDTH(WB), .CLK_DIV(DIV_B), .SYNC_POL(1'b1),
        .DEF_H_ACTIVE(8), .DEF_H_FRONT(2), .DEF_H_SYNC(3), .DEF_H_BACK(2),
        .DEF_V_ACTIVE(5), .DEF_V_FRONT(1), .DEF_V_SYNC(2), .DEF_V_BACK(1)) dut_b (
        .Clk(clk), .Rst_n(rst_b_n), .En(en_b),
        .H_active(cfg_b[0]), .H_front(cfg_b[1]), .H_sync(cfg_b[2]), .H_back(cfg_b[3]),
        .V_active(cfg_b[4]), .V_front(cfg_b[5]), .V_sync(cfg_b[6]), .V_back(cfg_b[7]),
        .Count_h(count_h_b), .Count_v(count_v_b), .Hsync(hsync_b), .Vsync(vsync_b),
        .Pixel_tick(tick_b), .Line_start(line_b), .Frame_start(frame_b));

    // Reference model: position is a linear pixel index within the frame.
    int m_phase, m_pix, m_frames;
    int m_sh [8];
    bit m_tick, m_line, m_frame;

    task automatic model_reset();
        m_phase = 0; m_pix = 0; m_sh = DEF_B;
        m_tick = 0; m_line = 0; m_frame = 0;
    endtask

    task automatic model_step();
        int ht, vt, cht, cvt;
        m_tick = 0; m_line = 0; m_frame = 0;
        if (!en_b) begin
            m_phase = 0;
        end else begin
            m_phase = (m_phase + 1) % DIV_B;
            if (m_phase == DIV_B - 1) begin
                m_tick = 1;
                ht = m_sh[0] + m_sh[1] + m_sh[2] + m_sh[3];
                vt = m_sh[4] + m_sh[5] + m_sh[6] + m_sh[7];
                m_pix++;
                m_line = (m_pix % ht == 0);
                if (m_pix == ht * vt) begin
                    m_pix = 0; m_frame = 1; m_frames++;
                    cht = int'(cfg_b[0]) + int'(cfg_b[1]) + int'(cfg_b[2]) + int'(cfg_b[3]);
                    cvt = int'(cfg_b[4]) + int'(cfg_b[5]) + int'(cfg_b[6]) + int'(cfg_b[7]);
                    if (cfg_b[0] != 0 && cfg_b[4] != 0 && cht <= (1 << WB) - 1 && cvt <= (1 << WB) - 1)
                        for (int i = 0; i < 8; i++) m_sh[i] = int'(cfg_b[i]);
                end
            end
        end
    endtask

    task automatic check_b(input string tag);
        int ht, h, v, hs, vs;
        ht = m_sh[0] + m_sh[1] + m_sh[2] + m_sh[3];
        h  = m_pix % ht;
        v  = m_pix / ht;
        hs = (h >= m_sh[0] + m_sh[1] && h < m_sh[0] + m_sh[1] + m_sh[2]) ? 1 : 0;
        vs = (v >= m_sh[4] + m_sh[5] && v < m_sh[4] + m_sh[5] + m_sh[6]) ? 1 : 0;
        check({tag, "_count_h"}, count_h_b, h);
        check({tag, "_count_v"}, count_v_b, v);
        check({tag, "_hsync"},   hsync_b,   hs);
        check({tag, "_vsync"},   vsync_b,   vs);
        check({tag, "_tick"},    tick_b,    m_tick);
        check({tag, "_line"},    line_b,    m_line);
        check({tag, "_frame"},   frame_b,   m_frame);
    endtask

    // Waits (bounded) for the next Pixel_tick of instance A; n = negedges waited.
    task automatic wait_tick_a(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!tick_a && n < 64);
        check("a_tick_timeout", tick_a, 1);
    endtask

    int n, prev_h, hs_first, hs_last, hs_num;

    initial begin
        cfg_a = '{11'd640, 11'd16, 11'd96, 11'd48, 11'd480, 11'd10, 11'd2, 11'd33};
        cfg_b = '{default: '0};
        m_frames = 0;
        model_reset();

        // ---- A: reset state
        en_a = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("a_rst_count_h", count_h_a, 0);
        check("a_rst_count_v", count_v_a, 0);
        check("a_rst_hsync", hsync_a, 1);
        check("a_rst_vsync", vsync_a, 1);
        check("a_rst_pulses", {tick_a, line_a, frame_a}, 0);
        rst_a_n = 1'b1;

        // ---- A: divider cadence
        wait_tick_a(n);
        check("a_first_tick_delay", n, 3);
        check("a_first_tick_h", count_h_a, 1);
        wait_tick_a(n);
        check("a_tick_period", n, 4);
        check("a_second_tick_h", count_h_a, 2);

        // ---- A: walk line 0, record the Hsync-low window, check the wrap
        hs_first = -1; hs_last = -1; hs_num = 0; prev_h = 2;
        for (int k = 0; k < 900; k++) begin
            wait_tick_a(n);
            if (count_h_a == 0) break;
            if (!hsync_a) begin
                if (hs_first < 0) hs_first = count_h_a;
                hs_last = count_h_a;
                hs_num++;
            end
            prev_h = count_h_a;
        end
        check("a_last_h_before_wrap", prev_h, 799);
        check("a_wrap_h", count_h_a, 0);
        check("a_wrap_v", count_v_a, 1);
        check("a_wrap_line_start", line_a, 1);
        check("a_wrap_frame_start", frame_a, 0);
        check("a_vsync_line1", vsync_a, 1);
        check("a_hsync_first", hs_first, 656);
        check("a_hsync_last", hs_last, 751);
        check("a_hsync_width", hs_num, 96);

        // ---- A: enable drop at Count_h=100
        for (int k = 0; k < 200 && count_h_a != 100; k++) wait_tick_a(n);
        check("a_reach_h100", count_h_a, 100);
        en_a = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("a_hold_h", count_h_a, 100);
            check("a_hold_v", count_v_a, 1);
            check("a_hold_hsync", hsync_a, 1);
            check("a_hold_tick", tick_a, 0);
        end
        en_a = 1'b1;
        wait_tick_a(n);
        check("a_resume_tick_delay", n, 3);
        check("a_resume_h", count_h_a, 101);

        // ---- A: asynchronous reset mid-line
        for (int k = 0; k < 300 && count_h_a != 300; k++) wait_tick_a(n);
        check("a_reach_h300", count_h_a, 300);
        #2 rst_a_n = 1'b0;
        #1;
        check("a_async_count_h", count_h_a, 0);
        check("a_async_count_v", count_v_a, 0);
        check("a_async_syncs", {hsync_a, vsync_a}, 2'b11);
        check("a_async_pulses", {tick_a, line_a, frame_a}, 0);
        @(negedge clk);
        rst_a_n = 1'b1;
        wait_tick_a(n);
        check("a_restart_delay", n, 3);
        check("a_restart_h", count_h_a, 1);
        check("a_restart_v", count_v_a, 0);
        en_a = 1'b0;

        // ---- B: randomized run against the model
        @(negedge clk);
        check_b("b_reset");
        rst_b_n = 1'b1;
        for (int cyc = 0; cyc < 30000; cyc++) begin
            en_b = ($urandom_range(9) != 0);
            cfg_b[0] = WB'($urandom_range(12));
            for (int i = 1; i < 8; i++) cfg_b[i] = WB'($urandom_range(8));
            cfg_b[4] = WB'($urandom_range(12));
            @(posedge clk);
            model_step();
            @(negedge clk);
            check_b("b_run");
            if ($urandom_range(4999) == 0) begin
                #2 rst_b_n = 1'b0;
                #1 model_reset();
                check_b("b_async_rst");
                @(negedge clk);
                rst_b_n = 1'b1;
            end
        end
        check("b_frames_seen", (m_frames >= 5) ? 1 : 0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
